lfsr_pattern_detector: RTL and testbench

//  Parametrised Fibonacci LFSR with programmable seed and taps, feeding a serial pattern detector.

---
 rtl/lfsr_pkg.sv | 34 +++
 rtl/lfsr_core.sv | 83 ++++++++
 rtl/lfsr_pattern_detector.sv | 134 +++++++++++++
 tb/tb_lfsr_pattern_detector.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants for the parametrised LFSR and its pattern detector.
//
// Contents:
//   TAPS_Wn      maximal-length Fibonacci feedback masks for common widths
//                (bit i set = state[i] takes part in the XOR feedback)
//   DEFAULT_SEED reset seed of the default 24-bit configuration
//   sat_inc      saturating +1 helper used by the hit counter
//
// Optional build feature (selected by the includer, not by this package):
//   LFSR_LOCKUP_RECOVER_EN  replace an all-zero state/seed by 1
package lfsr_pkg;

  localparam logic [3:0]  TAPS_W4  = 4'hC;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hD008;
  localparam logic [23:0] TAPS_W24 = 24'hE10000;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

  localparam logic [23:0] DEFAULT_SEED = 24'h000001;

  // Saturating increment on a 32-bit container; the caller passes the
  // all-ones value of its real counter width as the ceiling.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] ceiling);
    logic [31:0] result;
    if (value == ceiling) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR state register with seed load and step enable.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high; loads DEFAULT_SEED
//   enable       in   advance one step (ignored while load is high)
//   load         in   load seed_in (wins over enable)
//   seed_in      in   WIDTH  seed for load
//   state_o      out  WIDTH  current state (registered)
//   load_val_o   out  WIDTH  value a load would write this cycle
//   step_val_o   out  WIDTH  value a step would write this cycle
//
// Build option LFSR_LOCKUP_RECOVER_EN: an all-zero load value or step
// result is replaced by 1 so the register never sits in the XOR lockup.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 24,
  parameter logic [WIDTH-1:0] TAPS         = TAPS_W24,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = lfsr_pkg::DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state_o,
  output logic [WIDTH-1:0] load_val_o,
  output logic [WIDTH-1:0] step_val_o
);

  localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] step_raw_s;
  logic [WIDTH-1:0] step_val_s;
  logic [WIDTH-1:0] load_val_s;
  logic             fb_s;

  // Feedback, candidate load/step values and next-state selection.
  always_comb begin
    fb_s       = ^(state_q & TAPS);
    step_raw_s = {state_q[WIDTH-2:0], fb_s};
`ifdef LFSR_LOCKUP_RECOVER_EN
    if (step_raw_s == ZERO_VAL) begin
      step_val_s = ONE_VAL;
    end else begin
      step_val_s = step_raw_s;
    end
    if (seed_in == ZERO_VAL) begin
      load_val_s = ONE_VAL;
    end else begin
      load_val_s = seed_in;
    end
`else
    step_val_s = step_raw_s;
    load_val_s = seed_in;
`endif
    if (load) begin
      state_d = load_val_s;
    end else if (enable) begin
      state_d = step_val_s;
    end else begin
      state_d = state_q;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DEFAULT_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o    = state_q;
  assign load_val_o = load_val_s;
  assign step_val_o = step_val_s;

endmodule

// File: rtl/lfsr_pattern_detector.sv
// Parametrised Fibonacci LFSR feeding a serial pattern detector.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high
//   enable       in   advance the LFSR one step
//   load         in   load seed_in (priority over enable)
//   seed_in      in   WIDTH    seed for load
//   pattern      in   PAT_LEN  pattern to detect, MSB = oldest bit
//   lfsr_reg     out  WIDTH    current LFSR state
//   serial_out   out  1        lfsr_reg[WIDTH-1], shifted out on next step
//   seq_detected out  1        one-cycle pulse on a pattern match
//   hit_count    out  HIT_W    matches since reset/load, saturating
//   period_done  out  1        one-cycle pulse when state returns to seed
//
// Build option LFSR_LOCKUP_RECOVER_EN: all-zero seeds/states become 1.
// Without it an all-zero state is kept and period_done pulses every step.
module lfsr_pattern_detector
  import lfsr_pkg::*;
#(
  parameter int               WIDTH        = 24,
  parameter logic [WIDTH-1:0] TAPS         = TAPS_W24,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = lfsr_pkg::DEFAULT_SEED,
  parameter int               PAT_LEN      = 8,
  parameter int               HIT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               load,
  input  logic [WIDTH-1:0]   seed_in,
  input  logic [PAT_LEN-1:0] pattern,
  output logic [WIDTH-1:0]   lfsr_reg,
  output logic               serial_out,
  output logic               seq_detected,
  output logic [HIT_W-1:0]   hit_count,
  output logic               period_done
);

  localparam int                 FILL_W   = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(PAT_LEN);
  localparam logic [HIT_W-1:0]   HIT_MAX  = {HIT_W{1'b1}};

  logic [WIDTH-1:0]   lfsr_q;
  logic [WIDTH-1:0]   load_val_s;
  logic [WIDTH-1:0]   step_val_s;
  logic               step_s;

  logic [WIDTH-1:0]   seed_q,    seed_d;
  logic [PAT_LEN-1:0] history_q, history_d;
  logic [FILL_W-1:0]  fill_q,    fill_d;
  logic [HIT_W-1:0]   hit_q,     hit_d;
  logic               seq_q,     seq_d;
  logic               pd_q,      pd_d;

  lfsr_core #(
    .WIDTH        (WIDTH),
    .TAPS         (TAPS),
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .seed_in    (seed_in),
    .state_o    (lfsr_q),
    .load_val_o (load_val_s),
    .step_val_o (step_val_s)
  );

  assign step_s = enable & ~load;

  // Detector next-state: history/fill tracking, match, hit count, period.
  always_comb begin
    seed_d    = seed_q;
    history_d = history_q;
    fill_d    = fill_q;
    hit_d     = hit_q;
    seq_d     = 1'b0;
    pd_d      = 1'b0;
    if (load) begin
      // Latch the value actually loaded, so recovery from a zero seed
      // keeps the period compare consistent with the register.
      seed_d    = load_val_s;
      history_d = {PAT_LEN{1'b0}};
      fill_d    = {FILL_W{1'b0}};
      hit_d     = {HIT_W{1'b0}};
    end else if (step_s) begin
      history_d = {history_q[PAT_LEN-2:0], lfsr_q[WIDTH-1]};
      if (fill_q == FILL_MAX) begin
        fill_d = fill_q;
      end else begin
        fill_d = fill_q + {{(FILL_W-1){1'b0}}, 1'b1};
      end
      // A match needs PAT_LEN fresh bits since reset/load.
      seq_d = (history_d == pattern) && (fill_d == FILL_MAX);
      if (seq_d && (hit_q != HIT_MAX)) begin
        hit_d = HIT_W'(sat_inc(32'(hit_q), 32'(HIT_MAX)));
      end else begin
        hit_d = hit_q;
      end
      pd_d = (step_val_s == seed_q);
    end else begin
      seq_d = 1'b0;
      pd_d  = 1'b0;
    end
  end

  // Detector registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      seed_q    <= DEFAULT_SEED;
      history_q <= {PAT_LEN{1'b0}};
      fill_q    <= {FILL_W{1'b0}};
      hit_q     <= {HIT_W{1'b0}};
      seq_q     <= 1'b0;
      pd_q      <= 1'b0;
    end else begin
      seed_q    <= seed_d;
      history_q <= history_d;
      fill_q    <= fill_d;
      hit_q     <= hit_d;
      seq_q     <= seq_d;
      pd_q      <= pd_d;
    end
  end

  assign lfsr_reg     = lfsr_q;
  assign serial_out   = lfsr_q[WIDTH-1];
  assign seq_detected = seq_q;
  assign hit_count    = hit_q;
  assign period_done  = pd_q;

endmodule

// File: tb/tb_lfsr_pattern_detector.sv
// Self-checking bench for lfsr_pattern_detector: a default 24-bit instance
// and a 4-bit / PAT_LEN=4 / HIT_W=2 instance, checked against a
// bit-stream reference model plus directed vectors.
module tb_lfsr_pattern_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  // instance 0: defaults (24-bit, PAT_LEN 8, HIT_W 16)
  logic        en0, ld0;
  logic [23:0] seed0;
  logic [7:0]  pat0;
  logic [23:0] lfsr0;
  logic        ser0, seq0, pd0;
  logic [15:0] hit0;
  // instance 1: 4-bit, taps 1100, PAT_LEN 4, HIT_W 2
  logic        en1, ld1;
  logic [3:0]  seed1;
  logic [3:0]  pat1;
  logic [3:0]  lfsr1;
  logic        ser1, seq1, pd1;
  logic [1:0]  hit1;

  lfsr_pattern_detector dut0 (
    .clk(clk), .reset(reset), .enable(en0), .load(ld0), .seed_in(seed0),
    .pattern(pat0), .lfsr_reg(lfsr0), .serial_out(ser0),
    .seq_detected(seq0), .hit_count(hit0), .period_done(pd0)
  );

  lfsr_pattern_detector #(
    .WIDTH(4), .TAPS(4'b1100), .DEFAULT_SEED(4'h1), .PAT_LEN(4), .HIT_W(2)
  ) dut1 (
    .clk(clk), .reset(reset), .enable(en1), .load(ld1), .seed_in(seed1),
    .pattern(pat1), .lfsr_reg(lfsr1), .serial_out(ser1),
    .seq_detected(seq1), .hit_count(hit1), .period_done(pd1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each instance is modelled as: current state, latched seed, the list of
  // bits emitted since reset/load, and a saturating hit count.
  logic [31:0] m_state [2];
  logic [31:0] m_seed  [2];
  int          m_hit   [2];
  bit          m_seq   [2];
  bit          m_pd    [2];
  bit          bits0 [$];
  bit          bits1 [$];

  function automatic bit tail_matches(input bit q[$], input int plen,
                                      input logic [31:0] pat);
    if (q.size() < plen) return 1'b0;
    for (int i = 0; i < plen; i++)
      if (q[q.size() - plen + i] != pat[plen - 1 - i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model(input int id, input bit ld, input bit en,
                       input logic [31:0] seed_in, input logic [31:0] pat);
    int          w, plen, hmax, fb;
    logic [31:0] taps, mask, s, nxt;
    bit          q[$];
    w    = (id == 0) ? 24 : 4;
    plen = (id == 0) ? 8 : 4;
    hmax = (id == 0) ? 65535 : 3;
    taps = (id == 0) ? 32'hE10000 : 32'hC;
    mask = (32'd1 << w) - 32'd1;
    q    = (id == 0) ? bits0 : bits1;
    m_seq[id] = 1'b0;
    m_pd[id]  = 1'b0;
    if (reset) begin
      m_state[id] = 32'd1;
      m_seed[id]  = 32'd1;
      q.delete();
      m_hit[id]   = 0;
    end else if (ld) begin
      s = seed_in & mask;
`ifdef LFSR_LOCKUP_RECOVER_EN
      if (s == 32'd0) s = 32'd1;
`endif
      m_state[id] = s;
      m_seed[id]  = s;
      q.delete();
      m_hit[id]   = 0;
    end else if (en) begin
      s   = m_state[id];
      q.push_back(s[w-1]);
      if (q.size() > 40) void'(q.pop_front());
      fb  = $countones(s & taps) % 2;
      nxt = ((s << 1) | 32'(fb)) & mask;
`ifdef LFSR_LOCKUP_RECOVER_EN
      if (nxt == 32'd0) nxt = 32'd1;
`endif
      m_seq[id] = tail_matches(q, plen, pat);
      if (m_seq[id] && m_hit[id] < hmax) m_hit[id]++;
      m_pd[id]    = (nxt == m_seed[id]);
      m_state[id] = nxt;
    end
    if (id == 0) bits0 = q; else bits1 = q;
  endtask

  // One clock: sample #1 after the edge, advance model, compare all outputs.
  task automatic cyc();
    @(posedge clk);
    #1;
    model(0, ld0, en0, 32'(seed0), 32'(pat0));
    model(1, ld1, en1, 32'(seed1), 32'(pat1));
    check("m0_lfsr",   32'(lfsr0), m_state[0]);
    check("m0_serial", 32'(ser0),  32'(m_state[0][23]));
    check("m0_seq",    32'(seq0),  32'(m_seq[0]));
    check("m0_hit",    32'(hit0),  32'(m_hit[0]));
    check("m0_period", 32'(pd0),   32'(m_pd[0]));
    check("m1_lfsr",   32'(lfsr1), m_state[1]);
    check("m1_serial", 32'(ser1),  32'(m_state[1][3]));
    check("m1_seq",    32'(seq1),  32'(m_seq[1]));
    check("m1_hit",    32'(hit1),  32'(m_hit[1]));
    check("m1_period", 32'(pd1),   32'(m_pd[1]));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         en;
    bit         ld;
    logic [3:0] seed;
    logic [3:0] pat;
    logic [3:0] exp_lfsr;
    bit         exp_seq;
    logic [1:0] exp_hit;
    bit         exp_pd;
    bit         exp_ser_before;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [3:0] st_exp [15];
    bit         ser_exp [15];
    st_exp  = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
    ser_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[0] = '{1'b0, 1'b1, 4'h1, 4'b0001, 4'h1, 1'b0, 2'd0, 1'b0, 1'b0};
    for (int k = 1; k < 16; k++)
      tbl[k] = '{1'b1, 1'b0, 4'h0, 4'b0001, st_exp[k-1], (k == 4),
                 (k >= 4) ? 2'd1 : 2'd0, (k == 15), ser_exp[k-1]};

    reset = 1'b1;
    en0 = 1'b0; ld0 = 1'b0; seed0 = 24'h0; pat0 = 8'h0;
    en1 = 1'b0; ld1 = 1'b0; seed1 = 4'h0;  pat1 = 4'h0;

    // Reset held 10 cycles.
    repeat (10) cyc();
    check("rst_lfsr0", 32'(lfsr0), 32'h000001);
    check("rst_hit0",  32'(hit0),  32'd0);
    check("rst_seq0",  32'(seq0),  32'd0);
    check("rst_pd0",   32'(pd0),   32'd0);
    check("rst_lfsr1", 32'(lfsr1), 32'h1);
    reset = 1'b0;

    // Full 4-bit period with pattern 0001.
    for (int i = 0; i < 16; i++) begin
      en1 = tbl[i].en; ld1 = tbl[i].ld; seed1 = tbl[i].seed; pat1 = tbl[i].pat;
      if (i > 0) check("tbl_serial", 32'(ser1), 32'(tbl[i].exp_ser_before));
      cyc();
      check("tbl_lfsr", 32'(lfsr1), 32'(tbl[i].exp_lfsr));
      check("tbl_seq",  32'(seq1),  32'(tbl[i].exp_seq));
      check("tbl_hit",  32'(hit1),  32'(tbl[i].exp_hit));
      check("tbl_pd",   32'(pd1),   32'(tbl[i].exp_pd));
    end

    // Idle: everything frozen, no pulses.
    en1 = 1'b0;
    repeat (5) begin
      cyc();
      check("idle_lfsr", 32'(lfsr1), 32'h1);
      check("idle_hit",  32'(hit1),  32'd1);
      check("idle_seq",  32'(seq1),  32'd0);
    end

    // Three more periods: 4 matches total, 2-bit counter saturates at 3.
    en1 = 1'b1;
    repeat (45) cyc();
    check("sat_hit", 32'(hit1), 32'd3);

    // Load together with enable mid-stream: load wins and clears.
    en1 = 1'b0; ld1 = 1'b1; seed1 = 4'h1;
    cyc();
    ld1 = 1'b0; en1 = 1'b1;
    repeat (6) cyc();
    check("pre_load_hit", 32'(hit1), 32'd1);
    ld1 = 1'b1; seed1 = 4'h9;
    cyc();
    check("ldwin_lfsr", 32'(lfsr1), 32'h9);
    check("ldwin_hit",  32'(hit1),  32'd0);
    check("ldwin_seq",  32'(seq1),  32'd0);
    check("ldwin_pd",   32'(pd1),   32'd0);
    ld1 = 1'b0;
    repeat (4) cyc();
    check("post_load_hit", 32'(hit1), 32'd0);

    // All-zero seed.
    en1 = 1'b0; ld1 = 1'b1; seed1 = 4'h0;
    cyc();
    ld1 = 1'b0; en1 = 1'b1;
`ifdef LFSR_LOCKUP_RECOVER_EN
    check("zero_ld_lfsr", 32'(lfsr1), 32'h1);
    cyc(); check("zero_step1", 32'(lfsr1), 32'h2);
    cyc(); check("zero_step2", 32'(lfsr1), 32'h4);
    cyc(); check("zero_step3", 32'(lfsr1), 32'h9);
`else
    check("zero_ld_lfsr", 32'(lfsr1), 32'h0);
    repeat (3) begin
      cyc();
      check("zero_lfsr", 32'(lfsr1), 32'h0);
      check("zero_pd",   32'(pd1),   32'd1);
    end
`endif

    // Randomised traffic on both instances against the model.
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      en0 = ($urandom_range(0, 3) != 0);
      ld0 = ($urandom_range(0, 39) == 0);
      seed0 = ($urandom_range(0, 7) == 0) ? 24'h0 : 24'($urandom);
      if ($urandom_range(0, 63) == 0) pat0 = 8'($urandom);
      en1 = ($urandom_range(0, 3) != 0);
      ld1 = ($urandom_range(0, 29) == 0);
      seed1 = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 15) == 0) pat1 = 4'($urandom);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
